imem_fetch_port: RTL and testbench
==================================

Name: imem_fetch_port

Overview:
- Parametrised instruction memory with a request/response handshake, configurable read latency, a program-load write port, and fault reporting.
- Sits between the fetch stage (issues a PC, consumes an instruction) and the program loader.
- Replaces the fixed, zero-latency, combinational PC-to-instruction lookup.
- Supports one outstanding request at a time.

Parameters:
- ADDR_W, 64, width of request PC.
- DATA_W, 32, instruction word width.
- DEPTH, 1024, number of instruction words (power of two, at least 4).
- LATENCY, 1, cycles from request acceptance to resp_valid (at least 1).
- NOP_WORD, 32'hd503201f, word returned on any fault and the initial content of every memory entry.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  fetch request present.
- req_ready  output  1  block can accept a request this cycle.
- req_pc  input  ADDR_W  byte address of the instruction.
- resp_valid  output  1  response word valid.
- resp_ready  input  1  fetch stage consumes the response.
- resp_instr  output  DATA_W  instruction word.
- resp_pc  output  ADDR_W  PC of the returned word.
- resp_fault  output  2  bit0 = misaligned (req_pc[1:0] != 0); bit1 = out of range (req_pc>>2 >= DEPTH).
- flush  input  1  abandons any in-flight or held response.
- load_en  input  1  write one memory word.
- load_addr  input  clog2(DEPTH)  word index to write.
- load_data  input  DATA_W  word to write.

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Memory is initialised to NOP_WORD at time zero; rst does not alter memory contents.
- Reset values: state = IDLE, resp_valid = 0, resp_instr = 0, resp_pc = 0, resp_fault = 0, latency counter = 0. req_ready is combinational (state == IDLE && !flush), so it reads 1 in the cycle after reset.
- States and transitions:
  - IDLE: on req_valid && req_ready, capture req_pc and compute the word index (req_pc>>2, truncated after the range check). If LATENCY == 1, go to RESP; otherwise go to WAIT with counter = LATENCY-1.
  - WAIT: decrement the counter each cycle; when it reaches 1, go to RESP on the next edge.
  - RESP: resp_valid = 1. resp_instr, resp_pc and resp_fault are held stable until resp_valid && resp_ready, then go to IDLE. No back-to-back acceptance on the response cycle.
- Timing: a request accepted on edge T gives resp_valid high after edge T+LATENCY.
- Read data is sampled on the edge that enters RESP.
- Load write:
  - Takes effect on the edge it is asserted, in any state.
  - A load to the index being sampled on the same edge is NOT visible; the old word is returned.
  - A load to an index in a later request is visible.
- Faults:
  - If either fault bit is set, resp_instr = NOP_WORD and the memory is not read.
  - Both bits can be set together.
  - The out-of-range check uses all ADDR_W bits (no aliasing).
- flush:
  - In WAIT or RESP, return to IDLE on the next edge, with resp_valid deasserted after that edge; the dropped response is never presented.
  - In IDLE, no request is accepted that cycle.
  - flush combined with resp_ready in RESP: treated as flush (same outcome).
- rst mid-operation (WAIT or RESP): return to IDLE; outputs go to reset values and the response is lost.
- rst takes priority over flush, and flush over a request.
- Counter width is clog2(LATENCY)+1. LATENCY = 1 never enters WAIT.

Test Plan:
- Load and read: load index 0..3 with 8b1f03e5, f84000a4, 8b040086, f80010a6, LATENCY=1. Request PCs 0, 4, 8, 12 with resp_ready=1 → each response valid one cycle after acceptance with matching word and resp_pc, resp_fault=0; req_ready low from acceptance until the response handshake.
- Latency and backpressure: LATENCY=3, request PC 8, resp_ready held low for 5 cycles → resp_valid rises exactly 3 edges after acceptance; resp_instr stays 8b040086 throughout; drops the cycle after resp_ready=1.
- Faults: request PC 6 → resp_fault=01, instr=d503201f. Request PC 4*DEPTH → fault=10. Request PC 4*DEPTH+2 → fault=11. Request PC 0x1_0000_0000 → fault=10 (no aliasing to index 0).
- Load collision: LATENCY=1, index 2 = 8b040086. Accept PC 8 while loading index 2 with 12345678 on the sampling edge → returns 8b040086. Next request to PC 8 → returns 12345678.
- Flush: LATENCY=4, accept PC 4, assert flush at the 2nd WAIT cycle → no resp_valid ever appears for it; req_ready=1 the following cycle. Flush asserted while in RESP → resp_valid deasserted after the next edge.
- Reset mid-operation: assert rst during RESP → after the edge, all outputs are 0 and req_ready=1. Memory word at index 1 still reads f84000a4 on the next request.

Source files
------------

// File: rtl/imem_fetch_port.sv
// imem_fetch_port
// ---------------------------------------------------------------------------
// Instruction memory seen by the fetch stage through a request/response
// handshake. One request may be outstanding at a time; the response appears
// LATENCY cycles after the cycle in which the request was accepted and is held
// until the fetch stage takes it. A separate load port writes program words at
// any time. Bad PCs (misaligned and/or beyond the memory) are reported as
// faults and answered with NOP_WORD without touching the memory.
//
// Parameters:
//   ADDR_W    width of the request PC (byte address)
//   DATA_W    instruction word width
//   DEPTH     number of instruction words (power of two, >= 4)
//   LATENCY   cycles from acceptance to resp_valid (>= 1)
//   NOP_WORD  fault answer and power-up content of every entry
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   req_valid/req_ready   request handshake, req_pc is the byte address
//   resp_valid/resp_ready response handshake
//   resp_instr, resp_pc   returned word and the PC it belongs to
//   resp_fault            bit0 misaligned, bit1 out of range
//   flush                 drops any in-flight or held response
//   load_en/addr/data     program-load write port (word index)
// ---------------------------------------------------------------------------
module imem_fetch_port #(
  parameter int                ADDR_W   = 64,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 1024,
  parameter int                LATENCY  = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'hd503201f
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_pc,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_W-1:0]        resp_instr,
  output logic [ADDR_W-1:0]        resp_pc,
  output logic [1:0]               resp_fault,
  input  logic                     flush,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]        load_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
  logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
  logic [1:0]         pend_fault_q, pend_fault_d;
  logic               resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]  resp_instr_q, resp_instr_d;
  logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
  logic [1:0]         resp_fault_q, resp_fault_d;

  // Power-up content only; reset leaves the program intact.
  logic [DATA_W-1:0]  mem [DEPTH] = '{default: NOP_WORD};

  logic [IDX_W-1:0]   req_idx;
  logic [1:0]         req_fault;
  logic               enter_resp;
  logic [IDX_W-1:0]   rd_idx;
  logic [ADDR_W-1:0]  rd_pc;
  logic [1:0]         rd_fault;

  assign req_ready  = (state_q == IDLE) && !flush;
  assign resp_valid = resp_valid_q;
  assign resp_instr = resp_instr_q;
  assign resp_pc    = resp_pc_q;
  assign resp_fault = resp_fault_q;

  // The range check looks at every PC bit above the byte offset, so a large
  // PC never aliases onto a low word index.
  assign req_idx      = req_pc[IDX_W+1:2];
  assign req_fault[0] = |req_pc[1:0];
  assign req_fault[1] = req_pc[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH);

  // Next-state logic. The memory is read only on the transition into RESP,
  // either straight from the request (LATENCY == 1) or from the captured
  // pending request after the wait countdown.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_idx_d   = pend_idx_q;
    pend_pc_d    = pend_pc_q;
    pend_fault_d = pend_fault_q;
    resp_valid_d = resp_valid_q;
    resp_instr_d = resp_instr_q;
    resp_pc_d    = resp_pc_q;
    resp_fault_d = resp_fault_q;
    enter_resp   = 1'b0;
    rd_idx       = pend_idx_q;
    rd_pc        = pend_pc_q;
    rd_fault     = pend_fault_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          pend_idx_d   = req_idx;
          pend_pc_d    = req_pc;
          pend_fault_d = req_fault;
          if (LATENCY == 1) begin
            enter_resp = 1'b1;
            rd_idx     = req_idx;
            rd_pc      = req_pc;
            rd_fault   = req_fault;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // A flush together with resp_ready ends the same way as a flush.
        if (flush || resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Faulting requests never index the memory.
    if (enter_resp) begin
      state_d      = RESP;
      resp_valid_d = 1'b1;
      resp_pc_d    = rd_pc;
      resp_fault_d = rd_fault;
      resp_instr_d = (rd_fault != 2'b00) ? NOP_WORD : mem[rd_idx];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_idx_q   <= '0;
      pend_pc_q    <= '0;
      pend_fault_q <= '0;
      resp_valid_q <= 1'b0;
      resp_instr_q <= '0;
      resp_pc_q    <= '0;
      resp_fault_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_idx_q   <= pend_idx_d;
      pend_pc_q    <= pend_pc_d;
      pend_fault_q <= pend_fault_d;
      resp_valid_q <= resp_valid_d;
      resp_instr_q <= resp_instr_d;
      resp_pc_q    <= resp_pc_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // Program load. A write on the same edge as a read of that index lands
  // after the read, so the reader still sees the previous word.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port. Three instances with LATENCY 1, 3 and 4 share
// the load, flush, reset and response-ready inputs; only the selected one
// sees req_valid. Inputs change on the falling edge, outputs are sampled on
// the falling edge.
module tb_imem_fetch_port;

  localparam logic [31:0] NOP = 32'hd503201f;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [63:0] req_pc;
  logic        resp_ready;
  logic        flush;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  int          sel;

  logic [2:0]  req_valid_v;
  logic [2:0]  req_ready_v;
  logic [2:0]  resp_valid_v;
  logic [31:0] resp_instr_v [3];
  logic [63:0] resp_pc_v [3];
  logic [1:0]  resp_fault_v [3];

  logic        cur_ready;
  logic        cur_valid;
  logic [31:0] cur_instr;
  logic [63:0] cur_pc;
  logic [1:0]  cur_fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          dut;
    logic [63:0] pc;
    int          lat;
    int          hold;
    logic [31:0] exp_instr;
    logic [1:0]  exp_fault;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  // Route the request only to the selected instance and mux its outputs.
  always_comb begin
    req_valid_v = '0;
    for (int i = 0; i < 3; i++) begin
      if (sel == i) req_valid_v[i] = req_valid;
    end
    cur_ready = req_ready_v[sel];
    cur_valid = resp_valid_v[sel];
    cur_instr = resp_instr_v[sel];
    cur_pc    = resp_pc_v[sel];
    cur_fault = resp_fault_v[sel];
  end

  imem_fetch_port #(.LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
    .req_pc(req_pc), .resp_valid(resp_valid_v[0]), .resp_ready(resp_ready),
    .resp_instr(resp_instr_v[0]), .resp_pc(resp_pc_v[0]), .resp_fault(resp_fault_v[0]),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_fetch_port #(.LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
    .req_pc(req_pc), .resp_valid(resp_valid_v[1]), .resp_ready(resp_ready),
    .resp_instr(resp_instr_v[1]), .resp_pc(resp_pc_v[1]), .resp_fault(resp_fault_v[1]),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_fetch_port #(.LATENCY(4)) dut_l4 (
    .clk(clk), .rst(rst), .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]),
    .req_pc(req_pc), .resp_valid(resp_valid_v[2]), .resp_ready(resp_ready),
    .resp_instr(resp_instr_v[2]), .resp_pc(resp_pc_v[2]), .resp_fault(resp_fault_v[2]),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic loadWord(input logic [9:0] addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    nextCycle();
    load_en = 1'b0;
  endtask

  task automatic checkIdleZero(input string tag);
    #1;
    checkOutput({tag, "_valid"}, 64'(cur_valid), 64'd0);
    checkOutput({tag, "_instr"}, 64'(cur_instr), 64'd0);
    checkOutput({tag, "_pc"},    cur_pc,         64'd0);
    checkOutput({tag, "_fault"}, 64'(cur_fault), 64'd0);
    checkOutput({tag, "_ready"}, 64'(cur_ready), 64'd1);
  endtask

  // Issue one request, follow it through the wait cycles, optional
  // backpressure, and the response handshake. Called just after a negedge.
  task automatic applyStimulus(input vec_t v);
    sel       = v.dut;
    req_pc    = v.pc;
    req_valid = 1'b1;
    #1;
    checkOutput("req_ready_idle", 64'(cur_ready), 64'd1);
    nextCycle();
    req_valid = 1'b0;
    for (int k = 1; k < v.lat; k++) begin
      checkOutput("valid_during_wait", 64'(cur_valid), 64'd0);
      checkOutput("ready_during_wait", 64'(cur_ready), 64'd0);
      nextCycle();
    end
    checkOutput("resp_valid", 64'(cur_valid), 64'd1);
    checkOutput("resp_instr", 64'(cur_instr), 64'(v.exp_instr));
    checkOutput("resp_pc",    cur_pc,         v.pc);
    checkOutput("resp_fault", 64'(cur_fault), 64'(v.exp_fault));
    checkOutput("ready_in_resp", 64'(cur_ready), 64'd0);
    for (int k = 0; k < v.hold; k++) begin
      nextCycle();
      checkOutput("held_valid", 64'(cur_valid), 64'd1);
      checkOutput("held_instr", 64'(cur_instr), 64'(v.exp_instr));
    end
    resp_ready = 1'b1;
    nextCycle();
    resp_ready = 1'b0;
    #1;
    checkOutput("valid_after_handshake", 64'(cur_valid), 64'd0);
    checkOutput("ready_after_handshake", 64'(cur_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_pc = '0; resp_ready = 1'b0; flush = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0; sel = 0;

    // Fields: dut, pc, latency, hold cycles, expected word, expected fault.
    vecs[0] = '{0, 64'd0,            1, 0, 32'h8b1f03e5, 2'b00};
    vecs[1] = '{0, 64'd4,            1, 0, 32'hf84000a4, 2'b00};
    vecs[2] = '{0, 64'd8,            1, 0, 32'h8b040086, 2'b00};
    vecs[3] = '{0, 64'd12,           1, 0, 32'hf80010a6, 2'b00};
    vecs[4] = '{0, 64'd6,            1, 0, NOP,          2'b01};
    vecs[5] = '{0, 64'd4096,         1, 0, NOP,          2'b10};
    vecs[6] = '{0, 64'd4098,         1, 0, NOP,          2'b11};
    vecs[7] = '{0, 64'h1_0000_0000,  1, 0, NOP,          2'b10};
    vecs[8] = '{0, 64'd4092,         1, 0, NOP,          2'b00};
    vecs[9] = '{1, 64'd8,            3, 5, 32'h8b040086, 2'b00};

    nextCycle();
    nextCycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      checkIdleZero("reset");
    end
    sel = 0;

    loadWord(10'd0, 32'h8b1f03e5);
    loadWord(10'd1, 32'hf84000a4);
    loadWord(10'd2, 32'h8b040086);
    loadWord(10'd3, 32'hf80010a6);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Flush in the second WAIT cycle of the LATENCY=4 instance.
    sel = 2; req_pc = 64'd4; req_valid = 1'b1;
    nextCycle();
    req_valid = 1'b0;
    checkOutput("flush_wait1_valid", 64'(cur_valid), 64'd0);
    nextCycle();
    flush = 1'b1;
    nextCycle();
    flush = 1'b0;
    #1;
    checkOutput("flush_wait_ready", 64'(cur_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("flush_wait_no_resp", 64'(cur_valid), 64'd0);
      nextCycle();
    end

    // Flush while the response is being held.
    sel = 0; req_pc = 64'd12; req_valid = 1'b1;
    nextCycle();
    req_valid = 1'b0;
    checkOutput("flush_resp_before", 64'(cur_valid), 64'd1);
    flush = 1'b1;
    nextCycle();
    flush = 1'b0;
    #1;
    checkOutput("flush_resp_after", 64'(cur_valid), 64'd0);
    checkOutput("flush_resp_ready", 64'(cur_ready), 64'd1);
    nextCycle();
    checkOutput("flush_resp_stays_low", 64'(cur_valid), 64'd0);

    // Flush in IDLE blocks acceptance.
    req_pc = 64'd0; req_valid = 1'b1; flush = 1'b1;
    #1;
    checkOutput("flush_idle_ready", 64'(cur_ready), 64'd0);
    nextCycle();
    req_valid = 1'b0; flush = 1'b0;
    #1;
    checkOutput("flush_idle_not_accepted", 64'(cur_valid), 64'd0);

    // Load to the index sampled on the same edge returns the old word.
    req_pc = 64'd8; req_valid = 1'b1;
    load_en = 1'b1; load_addr = 10'd2; load_data = 32'h12345678;
    nextCycle();
    req_valid = 1'b0; load_en = 1'b0;
    checkOutput("collide_valid", 64'(cur_valid), 64'd1);
    checkOutput("collide_old_word", 64'(cur_instr), 64'h8b040086);
    resp_ready = 1'b1;
    nextCycle();
    resp_ready = 1'b0;
    applyStimulus('{0, 64'd8, 1, 0, 32'h12345678, 2'b00});

    // Reset while a response is held; memory survives.
    req_pc = 64'd4; req_valid = 1'b1;
    nextCycle();
    req_valid = 1'b0;
    checkOutput("rst_mid_before", 64'(cur_instr), 64'hf84000a4);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkIdleZero("rst_mid");
    applyStimulus('{0, 64'd4, 1, 0, 32'hf84000a4, 2'b00});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
